// File: rtl/rx_pkg.sv
// ----------------------------------------------------------------------------
// rx_pkg
// Shared types and constants for the receive-side data buffer.
//   rx_size_t     : encoding of the AHB-side read width on rx_size
//   RX_BUF_DEPTH  : default byte capacity of the buffer
//   RX_OCC_W      : width of the occupancy count for the default depth
//   rx_bytes()    : rx_size -> requested byte count (1, 2 or 4)
//   rx_byte_mask(): byte count -> mask keeping the low-order bytes of a word
// ----------------------------------------------------------------------------
package rx_pkg;

    localparam int RX_BUF_DEPTH = 64;
    // Occupancy needs one extra bit so that a full buffer (DEPTH) is representable.
    localparam int RX_OCC_W     = $clog2(RX_BUF_DEPTH) + 1;

    typedef enum logic [1:0] {
        RX_SZ_1 = 2'd0,
        RX_SZ_2 = 2'd1,
        RX_SZ_4 = 2'd2
    } rx_size_t;

    // Encoding 3 is not named; it is treated as a 4-byte read like RX_SZ_4.
    function automatic logic [2:0] rx_bytes(input logic [1:0] sz);
        logic [2:0] n;
        case (rx_size_t'(sz))
            RX_SZ_1: n = 3'd1;
            RX_SZ_2: n = 3'd2;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

    function automatic logic [31:0] rx_byte_mask(input logic [2:0] cnt);
        logic [31:0] m;
        m = '0;
        for (int k = 0; k < 4; k++) begin
            m[8*k +: 8] = (k < int'(cnt)) ? 8'hFF : 8'h00;
        end
        return m;
    endfunction

endpackage

// File: rtl/rx_fifo_mem.sv
// ----------------------------------------------------------------------------
// rx_fifo_mem
// DEPTH x 8 byte storage for the receive buffer. One synchronous write port
// and four combinational read ports at rd_addr .. rd_addr+3 (modulo DEPTH),
// packed little-endian so the byte at rd_addr lands in rd_word[7:0].
// The array is not reset; contents are only meaningful where the owner's
// occupancy count says they are.
//
// Ports:
//   clk      in   clock
//   wr_en    in   write this cycle
//   wr_addr  in   write address
//   wr_data  in   write byte
//   rd_addr  in   base read address
//   rd_word  out  {mem[a+3], mem[a+2], mem[a+1], mem[a]}
// ----------------------------------------------------------------------------
module rx_fifo_mem #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [31:0]   rd_word
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Address arithmetic is AW bits wide, so +1..+3 wraps modulo DEPTH for free.
    always_comb begin
        rd_word = '0;
        for (int k = 0; k < 4; k++) begin
            rd_word[8*k +: 8] = mem[rd_addr + AW'(k)];
        end
    end

endmodule

// File: rtl/rx_data_buffer.sv
// ----------------------------------------------------------------------------
// rx_data_buffer
// Receive-side byte buffer between the USB RX top level and the AHB slave.
// Bytes strobed in by the RX side are stored in a circular buffer and handed
// out in 1-, 2- or 4-byte little-endian reads. Occupancy is a separate
// counter; overflow (write while full) and underrun (read asked for more
// than was held) are sticky until clear or reset.
//
// Ports:
//   clk                   in   system clock
//   n_rst                 in   async active-low reset
//   store_RX_packet_data  in   write strobe, one byte per cycle
//   RX_packet_data        in   byte to store
//   clear                 in   synchronous flush, highest priority
//   get_rx_data           in   read request pulse
//   rx_size               in   read width: 0=1B, 1=2B, 2/3=4B
//   rx_data               out  registered read result, oldest byte in [7:0]
//   rx_data_valid         out  pulse the cycle after a read
//   buffer_occupancy      out  bytes held, 0..DEPTH
//   overflow              out  sticky: write dropped while full
//   underrun              out  sticky: read short of requested bytes
// ----------------------------------------------------------------------------
module rx_data_buffer
    import rx_pkg::*;
#(
    parameter int DEPTH = RX_BUF_DEPTH
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     store_RX_packet_data,
    input  logic [7:0]               RX_packet_data,
    input  logic                     clear,
    input  logic                     get_rx_data,
    input  logic [1:0]               rx_size,
    output logic [31:0]              rx_data,
    output logic                     rx_data_valid,
    output logic [$clog2(DEPTH):0]   buffer_occupancy,
    output logic                     overflow,
    output logic                     underrun
);

    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;

    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [OW-1:0] occ;

    logic          full;
    logic          wr_ok;
    logic [2:0]    req_n;
    logic [2:0]    grant_n;
    logic [2:0]    pop_n;
    logic [31:0]   rd_word;

    assign buffer_occupancy = occ;

    // Fullness is judged on the pre-cycle count, so a same-cycle read never
    // makes room for a write.
    assign full  = (occ == OW'(DEPTH));
    assign wr_ok = store_RX_packet_data && !full && !clear;

    always_comb begin
        req_n = rx_bytes(rx_size);
        if (occ < OW'(req_n)) begin
            grant_n = occ[2:0];
        end else begin
            grant_n = req_n;
        end
        pop_n = get_rx_data ? grant_n : 3'd0;
    end

    rx_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_ok),
        .wr_addr (wptr),
        .wr_data (RX_packet_data),
        .rd_addr (rptr),
        .rd_word (rd_word)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wptr          <= '0;
            rptr          <= '0;
            occ           <= '0;
            rx_data       <= '0;
            rx_data_valid <= 1'b0;
            overflow      <= 1'b0;
            underrun      <= 1'b0;
        end else if (clear) begin
            // rx_data deliberately keeps its last value across a flush.
            wptr          <= '0;
            rptr          <= '0;
            occ           <= '0;
            rx_data_valid <= 1'b0;
            overflow      <= 1'b0;
            underrun      <= 1'b0;
        end else begin
            rx_data_valid <= get_rx_data;

            if (get_rx_data) begin
                rx_data <= rd_word & rx_byte_mask(grant_n);
                // For DEPTH=4 a 4-byte pop truncates to 0, which is the same
                // position modulo DEPTH.
                rptr    <= rptr + AW'(grant_n);
                if (grant_n != req_n) begin
                    underrun <= 1'b1;
                end
            end

            if (store_RX_packet_data) begin
                if (full) begin
                    overflow <= 1'b1;
                end else begin
                    wptr <= wptr + AW'(1);
                end
            end

            occ <= occ + OW'(wr_ok) - OW'(pop_n);
        end
    end

endmodule

// File: tb/tb_rx_data_buffer.sv
module tb_rx_data_buffer;

    localparam int DEPTH = 64;

    logic        clk;
    logic        n_rst;
    logic        store_RX_packet_data;
    logic [7:0]  RX_packet_data;
    logic        clear;
    logic        get_rx_data;
    logic [1:0]  rx_size;
    logic [31:0] rx_data;
    logic        rx_data_valid;
    logic [6:0]  buffer_occupancy;
    logic        overflow;
    logic        underrun;

    rx_data_buffer #(.DEPTH(DEPTH)) dut (
        .clk                  (clk),
        .n_rst                (n_rst),
        .store_RX_packet_data (store_RX_packet_data),
        .RX_packet_data       (RX_packet_data),
        .clear                (clear),
        .get_rx_data          (get_rx_data),
        .rx_size              (rx_size),
        .rx_data              (rx_data),
        .rx_data_valid        (rx_data_valid),
        .buffer_occupancy     (buffer_occupancy),
        .overflow             (overflow),
        .underrun             (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_compared   = 0;
    int n_mismatched = 0;

    // Reference model state
    logic [7:0]  mq[$];
    logic [31:0] exp_q[$];
    logic        m_of;
    logic        m_uf;
    logic        exp_valid;
    logic [31:0] last_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        assert (obs === exp) else begin
            n_mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus, advance the model, and return #1 after the edge.
    task automatic cycle(input logic st, input logic [7:0] d, input logic gt,
                         input logic [1:0] sz, input logic clr);
        int          n;
        int          m;
        logic [31:0] w;
        bit          pre_full;
        store_RX_packet_data = st;
        RX_packet_data       = d;
        get_rx_data          = gt;
        rx_size              = sz;
        clear                = clr;
        if (clr) begin
            mq.delete();
            m_of      = 1'b0;
            m_uf      = 1'b0;
            exp_valid = 1'b0;
        end else begin
            pre_full  = (mq.size() == DEPTH);
            exp_valid = gt;
            if (gt) begin
                n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
                m = (mq.size() < n) ? mq.size() : n;
                w = '0;
                for (int k = 0; k < m; k++) w[8*k +: 8] = mq.pop_front();
                if (m < n) m_uf = 1'b1;
                exp_q.push_back(w);
            end
            if (st) begin
                if (pre_full) m_of = 1'b1;
                else mq.push_back(d);
            end
        end
        @(posedge clk);
        #1;
        store_RX_packet_data = 1'b0;
        RX_packet_data       = 8'h00;
        get_rx_data          = 1'b0;
        rx_size              = 2'd0;
        clear                = 1'b0;
    endtask

    task automatic wr(input logic [7:0] d);
        cycle(1'b1, d, 1'b0, 2'd0, 1'b0);
    endtask

    task automatic rd(input logic [1:0] sz);
        cycle(1'b0, 8'h00, 1'b1, sz, 1'b0);
    endtask

    task automatic check_status(input string tag);
        chk({tag, "_occ"},   32'(buffer_occupancy), 32'(mq.size()));
        chk({tag, "_ovf"},   32'(overflow),         32'(m_of));
        chk({tag, "_udr"},   32'(underrun),         32'(m_uf));
        chk({tag, "_valid"}, 32'(rx_data_valid),    32'(exp_valid));
    endtask

    // Scoreboard: each valid pulse consumes the oldest expected read result.
    always @(negedge clk) begin
        if (n_rst && rx_data_valid) begin
            if (exp_q.size() == 0) begin
                chk("valid_without_get", 32'(rx_data_valid), 32'd0);
            end else begin
                last_data = exp_q.pop_front();
                chk("rx_data", rx_data, last_data);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_rst = 1'b0;
        store_RX_packet_data = 1'b0;
        RX_packet_data = 8'h00;
        clear = 1'b0;
        get_rx_data = 1'b0;
        rx_size = 2'd0;
        m_of = 1'b0;
        m_uf = 1'b0;
        exp_valid = 1'b0;
        last_data = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_rx_data", rx_data, 32'h0);
        check_status("reset");
        n_rst = 1'b1;

        // Four bytes then a 4-byte read
        wr(8'hA1); wr(8'hB2); wr(8'hC3); wr(8'hD4);
        check_status("fill4");
        rd(2'd2);
        check_status("read4");
        chk("read4_word", rx_data, 32'hD4C3B2A1);

        // Short read -> underrun, then a read from empty
        wr(8'h11); wr(8'h22); wr(8'h33);
        rd(2'd2);
        check_status("short");
        rd(2'd0);
        check_status("empty_read");

        // Fill to capacity, overflow, then drain with full-rate reads
        cycle(1'b0, 8'h00, 1'b0, 2'd0, 1'b1);
        check_status("clear1");
        for (int i = 0; i < 64; i++) wr(8'(i));
        check_status("full");
        wr(8'h40);
        check_status("overflow");
        for (int i = 0; i < 16; i++) rd(2'd2);
        check_status("drained");

        // Pointer wrap
        cycle(1'b0, 8'h00, 1'b0, 2'd0, 1'b1);
        for (int i = 0; i < 60; i++) wr(8'(i + 8'h80));
        for (int i = 0; i < 15; i++) rd(2'd2);
        for (int i = 0; i < 8; i++) wr(8'(8'hE0 + i));
        check_status("wrap_fill");
        rd(2'd2);
        rd(2'd3);
        check_status("wrap_drain");

        // Simultaneous store and 2-byte get
        wr(8'h55); wr(8'h66);
        cycle(1'b1, 8'h77, 1'b1, 2'd1, 1'b0);
        check_status("simul");
        rd(2'd0);
        check_status("simul_after");

        // occupancy 10 with overflow, then clear alongside store and get
        for (int i = 0; i < 64; i++) wr(8'(i + 8'h10));
        wr(8'hEE);
        for (int i = 0; i < 13; i++) rd(2'd2);
        rd(2'd1);
        @(negedge clk);
        check_status("pre_clear");
        @(posedge clk); #1;
        cycle(1'b1, 8'hF0, 1'b1, 2'd2, 1'b1);
        check_status("clear2");
        chk("clear_holds_rx_data", rx_data, last_data);

        // Async reset mid-stream
        wr(8'h01); wr(8'h02); wr(8'h03);
        n_rst = 1'b0;
        #1;
        mq.delete();
        m_of = 1'b0;
        m_uf = 1'b0;
        exp_valid = 1'b0;
        chk("async_rst_rx_data", rx_data, 32'h0);
        check_status("async_rst");
        @(posedge clk); #1;
        n_rst = 1'b1;
        wr(8'h9A);
        rd(2'd0);
        check_status("post_rst");

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
